// File: rtl/reg_loader_pkg.sv
// reg_loader_pkg: shared types and constants for the byte-stream register loader.
// Frame layout: header (address in [6:0], parity in [7]), data high byte, data low byte.
package reg_loader_pkg;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    HI  = 2'd1,
    LO  = 2'd2,
    WR  = 2'd3
  } state_t;

  localparam int ADDR_LSB  = 0;
  localparam int ADDR_MSB  = 6;
  localparam int PAR_BIT   = 7;
  localparam int FRAME_LEN = 3;

  // Even-parity check over a whole frame: returns 1 when the bit count is odd.
  function automatic logic parity24(input logic [23:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/reg_loader.sv
// reg_loader: collects 3-byte frames from a valid/ready byte stream and issues a
// single registered write to a register file. Frames addressing a register
// beyond NUM_REGS are consumed and reported with a one-cycle err pulse.
// Optional feature macro: REG_LOADER_PARITY_EN (frame must have even parity).
module reg_loader
  import reg_loader_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int ADDR_W   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [15:0]       w_data,
  output logic              busy,
  output logic              err
);

  // Address limit held in 8 bits so that NUM_REGS = 128 still compares correctly.
  localparam logic [7:0] ADDR_LIMIT = 8'(NUM_REGS);

  state_t                       state;
  logic [ADDR_MSB-ADDR_LSB:0]   hdr_addr;
  logic [7:0]                   hi_byte;
  logic                         addr_ok;
  logic                         frame_ok;

  // Handshake and activity flags come straight from the state register.
  assign s_ready = (state != WR);
  assign busy    = (state != HDR);

  assign addr_ok = ({1'b0, hdr_addr} < ADDR_LIMIT);

`ifdef REG_LOADER_PARITY_EN
  logic hdr_par;

  // Keep the header parity bit so the whole frame can be checked with the low byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr_par <= 1'b0;
    end else if (state == HDR && s_valid) begin
      hdr_par <= s_data[PAR_BIT];
    end
  end

  assign frame_ok = addr_ok && !parity24({hdr_par, hdr_addr, hi_byte, s_data});
`else
  assign frame_ok = addr_ok;
`endif

  // Frame FSM with registered write-port and error outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= HDR;
      hdr_addr <= '0;
      hi_byte  <= '0;
      w_en     <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      err      <= 1'b0;
    end else begin
      w_en <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        HDR: begin
          if (s_valid) begin
            hdr_addr <= s_data[ADDR_MSB:ADDR_LSB];
            state    <= HI;
          end
        end
        HI: begin
          if (s_valid) begin
            hi_byte <= s_data;
            state   <= LO;
          end
        end
        LO: begin
          if (s_valid) begin
            state <= WR;
            if (frame_ok) begin
              w_en   <= 1'b1;
              w_addr <= hdr_addr[ADDR_W-1:0];
              w_data <= {hi_byte, s_data};
            end else begin
              err <= 1'b1;
            end
          end
        end
        WR: begin
          state <= HDR;
        end
        default: begin
          state <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_loader.sv
// tb_reg_loader: table-driven and randomized checks of reg_loader against a
// frame-level reference model (address range and optional even parity).
module tb_reg_loader;

  localparam int NUM_REGS = 2;
  localparam int ADDR_W   = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_data;
  logic              busy;
  logic              err;

  reg_loader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .w_en   (w_en),
    .w_addr (w_addr),
    .w_data (w_data),
    .busy   (busy),
    .err    (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0;
  int bad   = 0;

  // Reference state: what the register-file port should be holding.
  int last_addr = 0;
  int last_data = 0;
  int last_waits = 0;
  int wr_cyc = 0;

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  hi;
    logic [7:0]  lo;
    bit          ok_plain;
    bit          ok_par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_valid(input logic [7:0] h, input logic [7:0] hi, input logic [7:0] lo);
    bit ok;
    ok = (int'(h & 8'h7F) < NUM_REGS);
`ifdef REG_LOADER_PARITY_EN
    if (($countones({h, hi, lo}) % 2) != 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Enters and leaves just after a falling edge; the byte is accepted on the
  // rising edge inside the task.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_busy);
    int n;
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("busy_gap", 32'(busy), 32'(exp_busy));
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 10) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    if (n >= 10) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
    last_waits = n;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_frame(input logic [7:0] h, input logic [7:0] hi, input logic [7:0] lo,
                          input int g0, input int g1, input int g2,
                          input bit ok, input bit b2b, input string tag);
    send_byte(h, g0, 1'b0);
    send_byte(hi, g1, 1'b1);
    send_byte(lo, g2, 1'b1);
    // Now in the cycle right after the low byte was accepted.
    if (ok) begin
      last_addr = int'(h & 8'h7F);
      last_data = int'({hi, lo});
      wr_cyc    = cyc;
    end
    chk({tag, "_wen"},    32'(w_en),    32'(ok));
    chk({tag, "_err"},    32'(err),     32'(!ok));
    chk({tag, "_addr"},   32'(w_addr),  32'(last_addr));
    chk({tag, "_data"},   32'(w_data),  32'(last_data));
    chk({tag, "_busy"},   32'(busy),    32'd1);
    chk({tag, "_ready"},  32'(s_ready), 32'd0);
    if (!b2b) begin
      s_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk({tag, "_wen_after"},  32'(w_en),    32'd0);
      chk({tag, "_err_after"},  32'(err),     32'd0);
      chk({tag, "_busy_after"}, 32'(busy),    32'd0);
      chk({tag, "_rdy_after"},  32'(s_ready), 32'd1);
      chk({tag, "_addr_hold"},  32'(w_addr),  32'(last_addr));
      chk({tag, "_data_hold"},  32'(w_data),  32'(last_data));
    end
    $display("frame %s: %02h %02h %02h expect %s", tag, h, hi, lo, ok ? "write" : "err");
  endtask

  vec_t vecs[8];

  initial begin
    int c1;
    logic [7:0] h, hi, lo;
    bit ok;

    vecs[0] = '{8'h01, 8'hAB, 8'hCD, 1'b1, 1'b0};
    vecs[1] = '{8'h05, 8'h12, 8'h34, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h00, 8'h01, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h22, 8'h33, 1'b1, 1'b1};
    vecs[5] = '{8'h81, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h02, 8'h55, 8'hAA, 1'b0, 1'b0};

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    @(negedge clock);
    @(negedge clock);
    chk("rst_wen",  32'(w_en),   32'd0);
    chk("rst_err",  32'(err),    32'd0);
    chk("rst_busy", 32'(busy),   32'd0);
    chk("rst_addr", 32'(w_addr), 32'd0);
    chk("rst_data", 32'(w_data), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Fixed vectors with no gaps.
    for (int i = 0; i < 8; i++) begin
`ifdef REG_LOADER_PARITY_EN
      do_frame(vecs[i].hdr, vecs[i].hi, vecs[i].lo, 0, 0, 0, vecs[i].ok_par, 1'b0, $sformatf("vec%0d", i));
`else
      do_frame(vecs[i].hdr, vecs[i].hi, vecs[i].lo, 0, 0, 0, vecs[i].ok_plain, 1'b0, $sformatf("vec%0d", i));
`endif
    end

    // Back-to-back frames with s_valid held high.
    do_frame(8'h80, 8'h00, 8'h01, 0, 0, 0, 1'b1, 1'b1, "b2b_a");
    c1 = wr_cyc;
    do_frame(8'h00, 8'h22, 8'h33, 0, 0, 0, 1'b1, 1'b0, "b2b_b");
    chk("b2b_ready_low_cycles", 32'(last_waits), 32'd0);
    chk("b2b_write_spacing", 32'(wr_cyc - c1), 32'd4);

    // Reset in the middle of a frame discards it.
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b1);
    reset = 1'b1;
    #1;
    last_addr = 0;
    last_data = 0;
    chk("midrst_wen",  32'(w_en),   32'd0);
    chk("midrst_err",  32'(err),    32'd0);
    chk("midrst_busy", 32'(busy),   32'd0);
    chk("midrst_data", 32'(w_data), 32'd0);
    s_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ready", 32'(s_ready), 32'd1);
    do_frame(8'h00, 8'h22, 8'h33, 0, 0, 0, model_valid(8'h00, 8'h22, 8'h33), 1'b0, "after_rst");

    // Random frames with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      h  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) h[6:0] = 7'($urandom_range(0, 3));
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      ok = model_valid(h, hi, lo);
      do_frame(h, hi, lo, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
               ok, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
